// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared sizes, FSM states and helpers for the data RAM access controller
package mem_pkg;

    localparam int RAM_ADDR_W = 9;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Size 11 is an alias of word; fold it once at capture so the RAM only sees 00/01/10.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SIZE_WORD : size;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - pipeline request/response and RAM port signals of the access controller
interface mem_access_ctrl_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_signed;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_fault;

    logic              ram_enable;
    logic              ram_rw;
    logic              ram_se;
    logic [1:0]        ram_size;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    // slave: the controller itself; master: the pipeline plus the RAM around it
    modport slave (
        input  req_valid, req_write, req_signed, req_size, req_addr, req_wdata,
        input  rsp_ready, ram_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault,
        output ram_enable, ram_rw, ram_se, ram_size, ram_addr, ram_din
    );

    modport master (
        output req_valid, req_write, req_signed, req_size, req_addr, req_wdata,
        output rsp_ready, ram_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
        input  ram_enable, ram_rw, ram_se, ram_size, ram_addr, ram_din
    );

endinterface

// File: rtl/mem_access_ctrl_align_chk.sv
// rtl/mem_access_ctrl_align_chk.sv - combinational misalignment flag and force-aligned address (mem_align_chk)
module mem_align_chk
    import mem_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    output logic              misaligned,
    output logic [ADDR_W-1:0] addr_aligned
);

    always_comb begin
        misaligned   = 1'b0;
        addr_aligned = addr;
        case (size)
            SIZE_BYTE: begin
                misaligned = 1'b0;
            end
            SIZE_HALF: begin
                misaligned      = addr[0];
                addr_aligned[0] = 1'b0;
            end
            default: begin
                misaligned        = |addr[1:0];
                addr_aligned[1:0] = 2'b00;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store to data RAM controller; MISALIGN_TRAP_EN adds the fault check
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W   = RAM_ADDR_W,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_ctrl_if.slave  bus
);

    state_t            state;
    state_t            state_nxt;
    logic              wr_q;
    logic              sgn_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [2:0]        lat_cnt;
    logic              misaligned;
    logic [ADDR_W-1:0] addr_aligned;
    logic              accept;
    logic              rsp_done;
    logic              load_last;
    logic              access_done;

    mem_align_chk #(.ADDR_W(ADDR_W)) u_align (
        .size         (size_q),
        .addr         (addr_q),
        .misaligned   (misaligned),
        .addr_aligned (addr_aligned)
    );

    assign accept      = (state == IDLE) && bus.req_valid;
    assign rsp_done    = (state == RESP) && bus.rsp_ready;
    assign load_last   = (lat_cnt == 3'(READ_LAT - 1));
    assign access_done = (state == ACCESS) && (wr_q || load_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Every ram_* output is gated by ACCESS so the RAM bus stays at zero otherwise.
    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.ram_enable = 1'b0;
        bus.ram_rw     = 1'b0;
        bus.ram_se     = 1'b0;
        bus.ram_size   = 2'b00;
        bus.ram_addr   = '0;
        bus.ram_din    = '0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
`ifdef MISALIGN_TRAP_EN
                    state_nxt = CHECK;
`else
                    state_nxt = ACCESS;
`endif
                end
            end
            CHECK: begin
                state_nxt = misaligned ? RESP : ACCESS;
            end
            ACCESS: begin
                bus.ram_enable = 1'b1;
                bus.ram_rw     = wr_q;
                bus.ram_se     = sgn_q && (size_q != SIZE_WORD);
                bus.ram_size   = size_q;
                bus.ram_addr   = misaligned ? addr_aligned : addr_q;
                bus.ram_din    = wdata_q;
                if (wr_q || load_last) state_nxt = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= SIZE_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            lat_cnt <= '0;
        end else begin
            if (accept) begin
                wr_q    <= bus.req_write;
                sgn_q   <= bus.req_signed;
                size_q  <= norm_size(bus.req_size);
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if ((state == ACCESS) && !wr_q && !load_last) lat_cnt <= lat_cnt + 3'd1;
            else                                          lat_cnt <= '0;
            // rdata is zero outside a load response, which also covers stores and faults
            if (access_done)   rdata_q <= wr_q ? '0 : bus.ram_dout;
            else if (rsp_done) rdata_q <= '0;
        end
    end

    assign bus.rsp_rdata = rdata_q;

`ifdef MISALIGN_TRAP_EN
    logic fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                fault_q <= 1'b0;
        else if ((state == CHECK) && misaligned)   fault_q <= 1'b1;
        else if (rsp_done)                         fault_q <= 1'b0;
    end

    assign bus.rsp_fault = fault_q;
`else
    assign bus.rsp_fault = 1'b0;
`endif

endmodule
